// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS pipeline hazard control slice.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } md_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int         MD_CNT_W = 6;

endpackage

// File: rtl/md_sequencer.sv
// Mul/div occupancy sequencer: counts the unit latency and strobes the HI/LO write.
//
// state | meaning
// IDLE  | unit free, waiting for an accepted start from E
// BUSY  | operation in flight, md_cnt counting down to 0
// DONE  | result written to HI/LO this cycle (hilo_we=1)
module md_sequencer
  import mips_pkg::*;
#(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  input  logic mdop,
  output logic md_busy,
  output logic hilo_we
);

  localparam logic [MD_CNT_W-1:0] MUL_LOAD = MD_CNT_W'(MUL_LAT - 2);
  localparam logic [MD_CNT_W-1:0] DIV_LOAD = MD_CNT_W'(DIV_LAT - 2);

  md_state_e             state_q, state_d;
  logic [MD_CNT_W-1:0]   md_cnt_q, md_cnt_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      md_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    md_cnt_d = md_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = BUSY;
          md_cnt_d = mdop ? DIV_LOAD : MUL_LOAD;
        end
      end
      BUSY: begin
        if (md_cnt_q == '0) state_d = DONE;
        else                md_cnt_d = md_cnt_q - 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign md_busy = (state_q != IDLE);
  assign hilo_we = (state_q == DONE);

endmodule

// File: rtl/hazard_controller.sv
// Hazard sequencer: detects hazards forwarding cannot cover and drives pipeline stall/flush enables.
module hazard_controller
  import mips_pkg::*;
#(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [4:0]       rsD,
  input  logic [4:0]       rtD,
  input  logic             branchD,
  input  logic             mdstartD,
  input  logic             hiloreadD,
  input  logic             regwriteE,
  input  logic             memtoregE,
  input  logic [4:0]       writeregE,
  input  logic             mdstartE,
  input  logic             mdopE,
  input  logic             memtoregM,
  input  logic             regwriteM,
  input  logic [4:0]       writeregM,
  input  logic             memreqM,
  input  logic             memackM,
  output logic             stallF,
  output logic             stallD,
  output logic             stallE,
  output logic             stallM,
  output logic             flushE,
  output logic             flushW,
  output logic             md_busy,
  output logic             hilo_we,
  output logic [CNT_W-1:0] stall_cycles
);

  logic match_e, match_m;
  logic lwstall, brstall, mdstall, memstall;
  logic md_hazard;
  logic unused_regwrite_m;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

  assign unused_regwrite_m = regwriteM;

  // Register 0 is hardwired, so a zero destination never conflicts.
  assign match_e = (writeregE != REG_ZERO) && ((writeregE == rsD) || (writeregE == rtD));
  assign match_m = (writeregM != REG_ZERO) && ((writeregM == rsD) || (writeregM == rtD));

  assign md_hazard = md_busy | mdstartE;
  assign lwstall   = memtoregE & match_e;
  assign brstall   = branchD & ((regwriteE & match_e) | (memtoregM & match_m));
  assign mdstall   = (hiloreadD | mdstartD) & md_hazard;
  assign memstall  = memreqM & ~memackM;

  // A memory wait freezes everything including E, so E must not be flushed.
  always_comb begin
    stallF = 1'b0;
    stallD = 1'b0;
    stallE = 1'b0;
    stallM = 1'b0;
    flushE = 1'b0;
    flushW = 1'b0;
    if (memstall) begin
      stallF = 1'b1;
      stallD = 1'b1;
      stallE = 1'b1;
      stallM = 1'b1;
      flushW = 1'b1;
    end else if (lwstall | brstall | mdstall) begin
      stallF = 1'b1;
      stallD = 1'b1;
      flushE = 1'b1;
    end
  end

  md_sequencer #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT)
  ) u_md_sequencer (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (mdstartE & ~memstall),
    .mdop    (mdopE),
    .md_busy (md_busy),
    .hilo_we (hilo_we)
  );

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stallD && (stall_cycles_q != {CNT_W{1'b1}})) stall_cycles_d = stall_cycles_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) stall_cycles_q <= '0;
    else          stall_cycles_q <= stall_cycles_d;
  end

  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: behavioural model compare plus directed literal checks.
module tb_hazard_controller;

  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 32;
  localparam int CNT_W   = 5;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [4:0] rsD = '0, rtD = '0, writeregE = '0, writeregM = '0;
  logic branchD = 0, mdstartD = 0, hiloreadD = 0, regwriteE = 0, memtoregE = 0;
  logic mdstartE = 0, mdopE = 0, memtoregM = 0, regwriteM = 0, memreqM = 0, memackM = 0;
  logic stallF, stallD, stallE, stallM, flushE, flushW, md_busy, hilo_we;
  logic [CNT_W-1:0] stall_cycles;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  hazard_controller #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .rsD(rsD), .rtD(rtD), .branchD(branchD),
    .mdstartD(mdstartD), .hiloreadD(hiloreadD), .regwriteE(regwriteE),
    .memtoregE(memtoregE), .writeregE(writeregE), .mdstartE(mdstartE), .mdopE(mdopE),
    .memtoregM(memtoregM), .regwriteM(regwriteM), .writeregM(writeregM),
    .memreqM(memreqM), .memackM(memackM), .stallF(stallF), .stallD(stallD),
    .stallE(stallE), .stallM(stallM), .flushE(flushE), .flushW(flushW),
    .md_busy(md_busy), .hilo_we(hilo_we), .stall_cycles(stall_cycles));

  // Model: cycles left until the mul/div unit is free again, and the stall count.
  int m_left = 0;
  int m_cnt  = 0;

  function automatic logic hit(input logic [4:0] w);
    return (w != 0) && (w == rsD || w == rtD);
  endfunction

  function automatic logic m_memstall();
    return memreqM && !memackM;
  endfunction

  function automatic logic m_other();
    logic lw, br, md;
    lw = memtoregE && hit(writeregE);
    br = branchD && ((regwriteE && hit(writeregE)) || (memtoregM && hit(writeregM)));
    md = (hiloreadD || mdstartD) && (m_left > 0 || mdstartE);
    return lw || br || md;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_left = 0;
      m_cnt  = 0;
    end else begin
      if ((m_memstall() || m_other()) && m_cnt < (1 << CNT_W) - 1) m_cnt = m_cnt + 1;
      if (m_left > 0) m_left = m_left - 1;
      else if (mdstartE && !m_memstall()) m_left = mdopE ? DIV_LAT : MUL_LAT;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic ms, ot;
    ms = m_memstall();
    ot = m_other();
    chk("stallF", stallF, ms || ot);
    chk("stallD", stallD, ms || ot);
    chk("stallE", stallE, ms);
    chk("stallM", stallM, ms);
    chk("flushE", flushE, !ms && ot);
    chk("flushW", flushW, ms);
    chk("md_busy", md_busy, m_left > 0);
    chk("hilo_we", hilo_we, m_left == 1);
    chk("stall_cycles", stall_cycles, m_cnt);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rsD = 0; rtD = 0; writeregE = 0; writeregM = 0; branchD = 0; mdstartD = 0;
    hiloreadD = 0; regwriteE = 0; memtoregE = 0; mdstartE = 0; mdopE = 0;
    memtoregM = 0; regwriteM = 0; memreqM = 0; memackM = 0;
  endtask

  int pulses, edges;

  initial begin
    clear_inputs();
    #12 reset_n = 1'b1;
    step();
    chk("reset_stall_cycles", stall_cycles, 0);
    chk("reset_md_busy", md_busy, 0);

    // load-use on rs
    memtoregE = 1; writeregE = 8; rsD = 8; #1;
    chk("lw_stallD", stallD, 1);
    chk("lw_flushE", flushE, 1);
    step();
    clear_inputs();
    chk("lw_count", stall_cycles, 1);
    memtoregE = 1; writeregE = 0; rsD = 0; #1;
    chk("lw_r0_stallD", stallD, 0);
    step();
    clear_inputs();

    // branch depends on load in M
    branchD = 1; rtD = 9; memtoregM = 1; writeregM = 9; #1;
    chk("br_stallD", stallD, 1);
    chk("br_flushE", flushE, 1);
    step();
    memtoregM = 0; #1;
    chk("br_none_stallD", stallD, 0);
    chk("br_count", stall_cycles, 2);
    clear_inputs();

    // multiply with mfhi waiting in D
    mdstartE = 1; mdopE = 0; hiloreadD = 1;
    step();
    mdstartE = 0;
    pulses = 0; edges = 0;
    for (int i = 0; i < 10; i++) begin
      if (hilo_we) pulses++;
      if (!md_busy) break;
      step();
      edges++;
    end
    chk("mul_edges_to_idle", edges, MUL_LAT);
    chk("mul_hilo_pulses", pulses, 1);
    chk("mul_stallD_after", stallD, 0);
    chk("mul_count", stall_cycles, 7);
    clear_inputs();

    // divide with a second mult/div waiting in D
    mdstartE = 1; mdopE = 1;
    step();
    mdstartE = 0; mdopE = 0; mdstartD = 1;
    pulses = 0; edges = 0;
    for (int i = 0; i < 60; i++) begin
      if (hilo_we) pulses++;
      if (!md_busy) break;
      step();
      edges++;
    end
    chk("div_edges_to_idle", edges, DIV_LAT);
    chk("div_hilo_pulses", pulses, 1);
    chk("div_count_saturated", stall_cycles, 31);
    clear_inputs();

    // memory wait overlapping a load-use and a pending div start
    memreqM = 1; memackM = 0; memtoregE = 1; writeregE = 8; rtD = 8; mdstartE = 1; mdopE = 1;
    #1;
    chk("mem_stallM", stallM, 1);
    chk("mem_flushE", flushE, 0);
    chk("mem_flushW", flushW, 1);
    step(); step(); step();
    chk("mem_no_accept", md_busy, 0);
    memackM = 1; #1;
    chk("ack_flushE", flushE, 1);
    chk("ack_stallM", stallM, 0);
    step();
    clear_inputs();
    chk("ack_accept", md_busy, 1);

    // reset in the middle of the divide
    repeat (10) step();
    reset_n = 1'b0; #1;
    chk("rst_md_busy", md_busy, 0);
    chk("rst_stall_cycles", stall_cycles, 0);
    #1 reset_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (hilo_we) pulses++;
    end
    chk("rst_no_hilo", pulses, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
